// File: rtl/zed_led_sequencer.sv
// zed_led_sequencer: drives ZedBoard user LEDs LD7..LD0 through four display modes
// (SELFTEST 0xAB, COUNT, WALK, BOUNCE). BTNU is synchronized, debounced and advances
// the mode. A prescaler sets the pattern step rate.
// Latency: a held BTNU first sampled at edge k updates MODE/LD at edge k+1+DEBOUNCE_CYCLES;
// steps land every TICK_DIV cycles after reset or a mode change. No backpressure.
// Ports: GCLK clock; BTNC synchronous active-high reset; BTNU async mode button;
//        LD[7:0] registered LED drive; MODE[1:0] registered current mode.
// Optional build macro ZED_LED_HEARTBEAT_EN: LD[7] becomes a heartbeat that toggles
// on every step tick (reset value 1); the internal pattern is unchanged.
module zed_led_sequencer #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       GCLK,
    input  logic       BTNC,
    input  logic       BTNU,
    output logic [7:0] LD,
    output logic [1:0] MODE
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SELFTEST = 2'd0;
    localparam logic [1:0] ST_COUNT    = 2'd1;
    localparam logic [1:0] ST_WALK     = 2'd2;
    localparam logic [1:0] ST_BOUNCE   = 2'd3;

    localparam logic [7:0] PAT_SELFTEST = 8'hAB;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic          s1, s2, stable;
    logic [DW-1:0] dcnt;
    logic [PW-1:0] pcnt;
    logic          adv, tick;
    logic [1:0]    mode, mode_nxt;
    logic [7:0]    pat;
    logic          dir;

    // Advance only on the debounced rising edge; the release update has s2 == 0.
    assign adv      = s2 && !stable && (dcnt == D_LAST);
    assign tick     = (pcnt == P_LAST);
    assign mode_nxt = mode + 2'd1;

    // Synchronizer and debounce
    always_ff @(posedge GCLK) begin
        if (BTNC) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            dcnt   <= '0;
        end else begin
            s1 <= BTNU;
            s2 <= s1;
            if (s2 != stable) begin
                if (dcnt == D_LAST) begin
                    stable <= s2;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    // Prescaler; a mode change restarts the step period.
    always_ff @(posedge GCLK) begin
        if (BTNC || adv || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    // Mode FSM and pattern register. adv takes priority and swallows a coincident tick.
    always_ff @(posedge GCLK) begin
        if (BTNC) begin
            mode <= ST_SELFTEST;
            pat  <= PAT_SELFTEST;
            dir  <= DIR_LEFT;
        end else if (adv) begin
            mode <= mode_nxt;
            case (mode_nxt)
                ST_SELFTEST: pat <= PAT_SELFTEST;
                ST_COUNT:    pat <= 8'h00;
                ST_WALK:     pat <= 8'h01;
                default: begin
                    pat <= 8'h01;
                    dir <= DIR_LEFT;
                end
            endcase
        end else if (tick) begin
            case (mode)
                ST_SELFTEST: pat <= pat;
                ST_COUNT:    pat <= pat + 8'd1;
                ST_WALK:     pat <= {pat[6:0], pat[7]};
                default: begin
                    // Direction flips on the step that lands on an end LED.
                    if (dir == DIR_LEFT) begin
                        pat <= {pat[6:0], 1'b0};
                        if (pat == 8'h40)
                            dir <= DIR_RIGHT;
                    end else begin
                        pat <= {1'b0, pat[7:1]};
                        if (pat == 8'h02)
                            dir <= DIR_LEFT;
                    end
                end
            endcase
        end
    end

`ifdef ZED_LED_HEARTBEAT_EN
    logic hb;

    // Heartbeat follows the effective step ticks and survives mode changes.
    always_ff @(posedge GCLK) begin
        if (BTNC)
            hb <= 1'b1;
        else if (tick && !adv)
            hb <= ~hb;
    end

    assign LD = {hb, pat[6:0]};
`else
    assign LD = pat;
`endif

    assign MODE = mode;

endmodule

// File: tb/tb_zed_led_sequencer.sv
// Bench for zed_led_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Reference model: mode plus the edge of the last pattern load; the expected LED value
// is a closed-form function of mode and the number of whole step periods since that load.
module tb_zed_led_sequencer;

    localparam int TD = 4;
    localparam int DB = 3;
`ifdef ZED_LED_HEARTBEAT_EN
    localparam logic [7:0] M = 8'h7F;
`else
    localparam logic [7:0] M = 8'hFF;
`endif

    logic       GCLK;
    logic       BTNC;
    logic       BTNU;
    logic [7:0] LD;
    logic [1:0] MODE;

    zed_led_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .GCLK (GCLK),
        .BTNC (BTNC),
        .BTNU (BTNU),
        .LD   (LD),
        .MODE (MODE)
    );

    initial begin
        GCLK = 1'b0;
        forever #5 GCLK = ~GCLK;
    end

    int tests = 0;
    int fails = 0;

    // Model state
    int   cyc      = 0;
    int   load_cyc = 0;
    int   mode_m   = 0;
    int   hi_run   = 0;
    int   adv_at   = -1;
    logic hb_m     = 1'b1;

    function automatic logic [7:0] exp_ld();
        int n;
        int q;
        logic [7:0] p;
        n = (cyc - load_cyc) / TD;
        case (mode_m)
            0: p = 8'hAB;
            1: p = 8'(n % 256);
            2: p = 8'(1 << (n % 8));
            default: begin
                q = n % 14;
                p = (q <= 7) ? 8'(1 << q) : 8'(1 << (14 - q));
            end
        endcase
`ifdef ZED_LED_HEARTBEAT_EN
        p[7] = hb_m;
`endif
        return p;
    endfunction

    // One clock edge with the given inputs, then update the model; returns 1 ns after the edge.
    task automatic tick_clk(input logic btn, input logic rst);
        BTNU = btn;
        BTNC = rst;
        @(posedge GCLK);
        cyc++;
        if (rst) begin
            mode_m   = 0;
            load_cyc = cyc;
            hi_run   = 0;
            adv_at   = -1;
            hb_m     = 1'b1;
        end else begin
            if (adv_at == cyc) begin
                mode_m   = (mode_m + 1) % 4;
                load_cyc = cyc;
                adv_at   = -1;
            end else if (cyc > load_cyc && (cyc - load_cyc) % TD == 0) begin
                hb_m = ~hb_m;
            end
            // Third consecutive high sample: s2 has been high DB samples two edges later.
            if (btn) begin
                hi_run++;
                if (hi_run == DB) adv_at = cyc + 2;
            end else begin
                hi_run = 0;
            end
        end
        #1;
    endtask

    task automatic press_button();
        for (int i = 0; i < 3; i++) tick_clk(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick_clk(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick_clk(1'b0, 1'b1);
        tick_clk(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ((LD !== 8'hAB) || (MODE !== 2'd0)) begin
            fails++;
            $display("FAIL reset_values: LD=%h MODE=%0d expected LD=ab MODE=0", LD, MODE);
        end
        for (int i = 0; i < 20; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if (((LD & M) !== (8'hAB & M)) || (LD !== exp_ld()) || (MODE !== 2'd0)) begin
                fails++;
                $display("FAIL reset_hold: cycle %0d LD=%h MODE=%0d expected LD=%h MODE=0",
                         i, LD, MODE, exp_ld());
            end
        end
    endtask

    task automatic test_debounce();
        int k;
        tick_clk(1'b1, 1'b0);
        tick_clk(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if (MODE !== 2'd0) begin
                fails++;
                $display("FAIL debounce_glitch: MODE=%0d expected 0", MODE);
            end
        end
        k = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            tick_clk(1'b1, 1'b0);
            tests++;
            if ((LD !== exp_ld()) || (MODE !== 2'(mode_m))) begin
                fails++;
                $display("FAIL debounce_model: edge k+%0d LD=%h MODE=%0d expected LD=%h MODE=%0d",
                         cyc - k, LD, MODE, exp_ld(), mode_m);
            end
            if (cyc == k + 3) begin
                tests++;
                if (MODE !== 2'd0) begin
                    fails++;
                    $display("FAIL debounce_early: MODE=%0d expected 0", MODE);
                end
            end
            if (cyc == k + 4) begin
                tests++;
                if ((MODE !== 2'd1) || ((LD & M) !== 8'h00)) begin
                    fails++;
                    $display("FAIL debounce_adv: LD=%h MODE=%0d expected LD=00 MODE=1", LD, MODE);
                end
            end
            if (cyc == k + 8 || cyc == k + 12) begin
                tests++;
                if ((LD & M) !== ((cyc == k + 8) ? 8'h01 : 8'h02)) begin
                    fails++;
                    $display("FAIL count_step: edge k+%0d LD=%h expected %h", cyc - k, LD,
                             (cyc == k + 8) ? 8'h01 : 8'h02);
                end
            end
        end
        for (int i = 0; i < 5; i++) tick_clk(1'b0, 1'b0);
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 1100 && (cyc - load_cyc) < 1028; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if (LD !== exp_ld()) begin
                fails++;
                $display("FAIL count_model: step %0d LD=%h expected %h",
                         (cyc - load_cyc) / TD, LD, exp_ld());
            end
            if ((cyc - load_cyc) == 1020 || (cyc - load_cyc) == 1024) begin
                tests++;
                if ((LD & M) !== (((cyc - load_cyc) == 1020) ? (8'hFF & M) : 8'h00)) begin
                    fails++;
                    $display("FAIL count_wrap: LD=%h at step %0d", LD, (cyc - load_cyc) / TD);
                end
            end
        end
    endtask

    task automatic test_walk_bounce();
        press_button();
        tests++;
        if (MODE !== 2'd2) begin
            fails++;
            $display("FAIL walk_mode: MODE=%0d expected 2", MODE);
        end
        for (int i = 0; i < 60 && (cyc - load_cyc) < 36; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if (LD !== exp_ld()) begin
                fails++;
                $display("FAIL walk_model: LD=%h expected %h", LD, exp_ld());
            end
            if ((cyc - load_cyc) == 28 || (cyc - load_cyc) == 32) begin
                tests++;
                if ((LD & M) !== ((((cyc - load_cyc) == 28) ? 8'h80 : 8'h01) & M)) begin
                    fails++;
                    $display("FAIL walk_wrap: LD=%h at offset %0d", LD, cyc - load_cyc);
                end
            end
        end
        press_button();
        tests++;
        if (MODE !== 2'd3) begin
            fails++;
            $display("FAIL bounce_mode: MODE=%0d expected 3", MODE);
        end
        for (int i = 0; i < 90 && (cyc - load_cyc) < 64; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if (LD !== exp_ld()) begin
                fails++;
                $display("FAIL bounce_model: LD=%h expected %h", LD, exp_ld());
            end
            if ((cyc - load_cyc) == 28) begin
                tests++;
                if ((LD & M) !== (8'h80 & M)) begin
                    fails++;
                    $display("FAIL bounce_top: LD=%h expected 80", LD);
                end
            end
            if ((cyc - load_cyc) == 32) begin
                tests++;
                if ((LD & M) !== 8'h40) begin
                    fails++;
                    $display("FAIL bounce_turn_right: LD=%h expected 40", LD);
                end
            end
            if ((cyc - load_cyc) == 56 || (cyc - load_cyc) == 60) begin
                tests++;
                if ((LD & M) !== (((cyc - load_cyc) == 56) ? 8'h01 : 8'h02)) begin
                    fails++;
                    $display("FAIL bounce_turn_left: LD=%h at offset %0d", LD, cyc - load_cyc);
                end
            end
        end
    endtask

    task automatic test_collision();
        int e;
        do_reset();
        press_button();
        for (int i = 0; i < 20; i++) begin
            if ((cyc - load_cyc) >= 6 && (cyc + 1 - load_cyc) % TD == 0) break;
            tick_clk(1'b0, 1'b0);
        end
        // Press sampled from edge cyc+1, so the advance lands on a step edge.
        e = cyc + 1 + 4;
        for (int i = 0; i < 12; i++) begin
            tick_clk(i < 3, 1'b0);
            tests++;
            if ((LD !== exp_ld()) || (MODE !== 2'(mode_m))) begin
                fails++;
                $display("FAIL collision_model: LD=%h MODE=%0d expected LD=%h MODE=%0d",
                         LD, MODE, exp_ld(), mode_m);
            end
            if (cyc == e || cyc == e + 3) begin
                tests++;
                if ((LD & M) !== 8'h01 || MODE !== 2'd2) begin
                    fails++;
                    $display("FAIL collision_load: LD=%h MODE=%0d expected LD=01 MODE=2", LD, MODE);
                end
            end
            if (cyc == e + 4) begin
                tests++;
                if ((LD & M) !== 8'h02) begin
                    fails++;
                    $display("FAIL collision_next_step: LD=%h expected 02", LD);
                end
            end
        end
        do_reset();
        for (int j = 1; j <= 4; j++) begin
            press_button();
            tests++;
            if (MODE !== 2'(j % 4)) begin
                fails++;
                $display("FAIL mode_wrap_step: MODE=%0d expected %0d", MODE, j % 4);
            end
        end
        tests++;
        if ((MODE !== 2'd0) || ((LD & M) !== (8'hAB & M))) begin
            fails++;
            $display("FAIL mode_wrap: LD=%h MODE=%0d expected LD=ab MODE=0", LD, MODE);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < 3; j++) press_button();
        for (int i = 0; i < 22; i++) tick_clk(1'b0, 1'b0);
        tick_clk(1'b0, 1'b1);
        tests++;
        if ((LD !== 8'hAB) || (MODE !== 2'd0)) begin
            fails++;
            $display("FAIL reset_mid: LD=%h MODE=%0d expected LD=ab MODE=0", LD, MODE);
        end
        for (int i = 0; i < 8; i++) begin
            tick_clk(1'b0, 1'b0);
            tests++;
            if ((LD !== exp_ld()) || (MODE !== 2'd0)) begin
                fails++;
                $display("FAIL reset_mid_hold: LD=%h MODE=%0d expected LD=%h MODE=0",
                         LD, MODE, exp_ld());
            end
        end
    endtask

    task automatic test_hold_through_reset();
        int r;
        tick_clk(1'b1, 1'b1);
        tick_clk(1'b1, 1'b1);
        r = cyc;
        for (int i = 0; i < 8; i++) begin
            tick_clk(1'b1, 1'b0);
            tests++;
            if ((LD !== exp_ld()) || (MODE !== 2'(mode_m))) begin
                fails++;
                $display("FAIL hold_reset_model: LD=%h MODE=%0d expected LD=%h MODE=%0d",
                         LD, MODE, exp_ld(), mode_m);
            end
            if (cyc == r + DB + 1 || cyc == r + DB + 2) begin
                tests++;
                if (MODE !== ((cyc == r + DB + 2) ? 2'd1 : 2'd0)) begin
                    fails++;
                    $display("FAIL hold_reset_adv: edge r+%0d MODE=%0d", cyc - r, MODE);
                end
            end
        end
        for (int i = 0; i < 5; i++) tick_clk(1'b0, 1'b0);
    endtask

    task automatic test_random();
        int len;
        int gap;
        do_reset();
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(6, 1);
            gap = $urandom_range(12, 4);
            for (int i = 0; i < len + gap; i++) begin
                tick_clk(i < len, 1'b0);
                tests++;
                if ((LD !== exp_ld()) || (MODE !== 2'(mode_m))) begin
                    fails++;
                    $display("FAIL random_model: pulse %0d LD=%h MODE=%0d expected LD=%h MODE=%0d",
                             p, LD, MODE, exp_ld(), mode_m);
                end
            end
        end
    endtask

    initial begin
        BTNU = 1'b0;
        BTNC = 1'b1;
        test_reset();
        test_debounce();
        test_count_wrap();
        test_walk_bounce();
        test_collision();
        test_reset_mid();
        test_hold_through_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zed_led_sequencer.md
# zed_led_sequencer

LED pattern controller that owns the ZedBoard user LEDs LD7..LD0 and sequences them through four display modes. BTNU, synchronized and debounced, advances the mode. A prescaler sets the pattern step rate. The block sits between the board pins and the top level, and replaces the static drive used for bring-up; its power-on pattern is that same self-test value, 0xAB.

## Interface
Parameters:
- TICK_DIV, default 50_000_000. Pattern step period in GCLK cycles (2 Hz at 100 MHz). Must be ≥ 2.
- DEBOUNCE_CYCLES, default 1_000_000. Consecutive cycles (10 ms) the synchronized BTNU must disagree with its debounced state before that state updates. Must be ≥ 2.

Ports:
- GCLK  in  1  100 MHz clock. Single clock domain.
- BTNC  in  1  Reset. Synchronous to GCLK, active-high.
- BTNU  in  1  Mode-advance button. Asynchronous, active-high.
- LD  out  8  LED drive. LD[i] drives pin LDi. Registered.
- MODE  out  2  Current mode. Registered. Debug/status output.

## Operation
- **Synchronizer:** 2-flop synchronizer on BTNU (s1 → s2).
- **Debounce:**
  - Counter dcnt increments each cycle s2 ≠ stable.
  - dcnt clears to 0 on any cycle s2 == stable.
  - When dcnt == DEBOUNCE_CYCLES-1 and s2 ≠ stable: stable ← s2 and dcnt ← 0.
  - adv is asserted combinationally in exactly that update cycle when s2 == 1, i.e. on the rising edge of the debounced button only.
- **Prescaler:**
  - pcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted when pcnt == TICK_DIV-1.
  - pcnt clears to 0 on adv.
- **Mode FSM:** SELFTEST(0) → COUNT(1) → WALK(2) → BOUNCE(3) → SELFTEST, advancing once per adv.
- **Pattern load on adv:** on the same edge as the mode change, the pattern register loads the new mode's initial value:
  - SELFTEST: 0xAB.
  - COUNT: 0x00.
  - WALK: 0x01.
  - BOUNCE: 0x01, with dir = left.
- **Pattern step on tick (no adv):**
  - SELFTEST: hold.
  - COUNT: pattern + 1, modulo 256 (0xFF → 0x00).
  - WALK: rotate left by 1 (0x80 → 0x01).
  - BOUNCE:
    - dir = left: shift left. When the result is 0x80, dir ← right.
    - dir = right: shift right. When the result is 0x01, dir ← left.
    - Sequence: 01,02,04,…,80,40,…,02,01,02,…
- **Simultaneous adv and tick:** adv wins. The tick is discarded and pcnt clears.
- **Outputs:** LD = pattern register; MODE = mode register.

## Timing
- **Reset:** all state is reset on any GCLK edge with BTNC = 1, including mid-sequence. Reset values:
  - LD = 0xAB, MODE = 0.
  - s1 = s2 = stable = 0, dcnt = pcnt = 0, dir = left.
  - Heartbeat (if built) = 1.
- **Button latency:** let edge k be the first edge at which BTNU is sampled 1, with BTNU held high.
  - s2 = 1 after edge k+1.
  - MODE and LD update at edge k+1+DEBOUNCE_CYCLES.
  - Any BTNU pulse or glitch shorter than DEBOUNCE_CYCLES cycles (as seen at s2) produces no advance.
- **Release:** release is debounced the same way and produces no adv.
- **Step latency:**
  - The first tick after reset or adv occurs TICK_DIV cycles later.
  - LD updates at the edge on which tick is asserted.
  - Steps are exactly TICK_DIV cycles apart thereafter.
- **BTNU held through reset release:** stable is 0 after reset, so one advance occurs DEBOUNCE_CYCLES+2 edges after release. This is required behaviour.

## Configuration
- **ZED_LED_HEARTBEAT_EN defined:**
  - A heartbeat flop (reset value 1) toggles on every tick, in all modes.
  - LD[7] is driven by the heartbeat; LD[6:0] come from the pattern register.
  - The internal pattern still evolves in all 8 bits, so COUNT, WALK and BOUNCE sequencing is unchanged internally.
  - The heartbeat is not reset on adv.
- **Not defined:** LD[7] = pattern[7]; no heartbeat logic is built.

## Test plan
All scenarios use TICK_DIV = 4 and DEBOUNCE_CYCLES = 3.
- **Reset:** BTNC high 2 cycles, then low → LD = 0xAB and MODE = 0 immediately after reset; LD holds 0xAB for 20 cycles.
- **Debounce:**
  - BTNU high for 2 cycles → no MODE change.
  - BTNU high held from edge k → MODE = 1 and LD = 0x00 at edge k+4.
  - Then LD = 0x01 at edge k+8 and 0x02 at edge k+12.
- **COUNT wrap:** in COUNT, run 256 ticks → LD returns to 0x00 after 0xFF.
- **WALK and BOUNCE:**
  - WALK: LD runs 0x01 … 0x80, then 0x01.
  - BOUNCE: LD runs 0x01 … 0x80, 0x40 … 0x01, 0x02; dir flips exactly at 0x80 and at 0x01.
- **Collision and mode wrap:**
  - Time adv onto the same cycle as tick → only the mode load occurs, and the next step comes 4 cycles later.
  - Four advances from SELFTEST → MODE = 0 and LD = 0xAB.
- **Reset mid-operation and heartbeat build:**
  - Assert BTNC mid-BOUNCE → LD = 0xAB and MODE = 0 on the next edge.
  - With ZED_LED_HEARTBEAT_EN defined: LD[7] toggles every 4 cycles starting from 1, in all modes.
